// File: rtl/max7219_pkg.sv
// Shared constants, state types and frame builders for the MAX7219 transmitter.
// MAX7219_DP_EN: when defined, digit frames for h_ones and m_ones carry the DP bit.
package max7219_pkg;

   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   localparam logic [7:0] DATA_DECODE    = 8'hFF;
   localparam logic [7:0] DATA_SCANLIMIT = 8'h05;
   localparam logic [7:0] DATA_SHUTDOWN  = 8'h01;
   localparam logic [7:0] DATA_TEST      = 8'h00;

   localparam int unsigned N_INIT_FRAMES  = 5;
   localparam int unsigned N_DIGIT_FRAMES = 6;

   typedef enum logic [1:0] {
      SEQ_INIT,
      SEQ_IDLE,
      SEQ_DIGITS
   } seq_state_e;

   typedef enum logic [2:0] {
      FR_IDLE,
      FR_LOAD,
      FR_SHIFT,
      FR_LATCH,
      FR_GAP
   } frame_state_e;

`ifdef MAX7219_DP_EN
   localparam bit DP_EN = 1'b1;
`else
   localparam bit DP_EN = 1'b0;
`endif

   function automatic logic [15:0] make_frame(input logic [3:0] addr, input logic [7:0] data);
      return {4'b0000, addr, data};
   endfunction

   function automatic logic [15:0] init_frame(input logic [2:0] idx, input logic [3:0] intensity);
      case (idx)
         3'd0:    return make_frame(ADDR_DECODE, DATA_DECODE);
         3'd1:    return make_frame(ADDR_INTENSITY, {4'h0, intensity});
         3'd2:    return make_frame(ADDR_SCANLIMIT, DATA_SCANLIMIT);
         3'd3:    return make_frame(ADDR_SHUTDOWN, DATA_SHUTDOWN);
         default: return make_frame(ADDR_TEST, DATA_TEST);
      endcase
   endfunction

   // idx 0 selects h_tens (bits 23:20) and goes to digit address 1.
   function automatic logic [15:0] digit_frame(input logic [2:0] idx, input logic [23:0] digits);
      logic [3:0] d;
      logic       dp;
      d  = 4'(digits >> (5'd20 - {idx, 2'b00}));
      dp = DP_EN && ((idx == 3'd1) || (idx == 3'd3));
      return make_frame({1'b0, idx} + 4'd1, {dp, 3'b000, d});
   endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Shifts one 16-bit frame out MSB first on CS/SCK/MOSI, then holds CS high for
// one half-period; done pulses in the last gap cycle so the next start can follow directly.
module spi_frame_tx
   import max7219_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 2
) (
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic [15:0] frame,
   output logic        done,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi
);

   localparam int unsigned      CNT_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

   frame_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic [15:0]      shreg_q, shreg_d;
   logic             cs_n_q, cs_n_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             half_end;

   assign half_end = (cnt_q == CNT_LAST);
   assign done     = (state_q == FR_GAP) && half_end;

   always_comb begin
      state_d = state_q;
      cnt_d   = half_end ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      cs_n_d  = cs_n_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;

      case (state_q)
         FR_IDLE: cnt_d = '0;
         FR_LOAD: begin
            if (half_end) begin
               sck_d   = 1'b1;
               state_d = FR_SHIFT;
            end
         end
         FR_SHIFT: begin
            if (half_end) begin
               if (sck_q) begin
                  sck_d   = 1'b0;
                  mosi_d  = shreg_q[14];
                  shreg_d = {shreg_q[14:0], 1'b0};
                  bit_d   = bit_q + 4'd1;
               end else begin
                  sck_d = 1'b1;
                  // bit_q counts completed bits, so this rise is the 16th
                  if (bit_q == 4'd15) state_d = FR_LATCH;
               end
            end
         end
         FR_LATCH: begin
            if (half_end) begin
               sck_d   = 1'b0;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               state_d = FR_GAP;
            end
         end
         FR_GAP: begin
            if (half_end) state_d = FR_IDLE;
         end
         default: state_d = FR_IDLE;
      endcase

      if (start && ((state_q == FR_IDLE) || done)) begin
         state_d = FR_LOAD;
         cnt_d   = '0;
         bit_d   = 4'd0;
         shreg_d = frame;
         cs_n_d  = 1'b0;
         sck_d   = 1'b0;
         mosi_d  = frame[15];
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= FR_IDLE;
         cnt_q   <= '0;
         bit_q   <= 4'd0;
         shreg_q <= 16'h0000;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         cs_n_q  <= cs_n_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
      end
   end

   assign spi_cs_n = cs_n_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;

endmodule

// File: rtl/max7219_digit_tx.sv
// MAX7219 sequencer: chip init after reset, then six digit frames per update.
// MAX7219_DP_EN (see max7219_pkg) adds separator dots on h_ones and m_ones.
module max7219_digit_tx
   import max7219_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 2,
   parameter logic [3:0]  INTENSITY   = 4'd8
) (
   input  logic        clk,
   input  logic        res,
   input  logic        update,
   input  logic [23:0] digits,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   output logic        busy
);

   seq_state_e  state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [23:0] snap_q, snap_d;
   logic        pend_q, pend_d;
   logic        start;
   logic [15:0] frame;
   logic        done;
   logic        req;
   logic        launch;

   // idx_q counts frames already launched in the current sequence
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      pend_d  = pend_q;
      start   = 1'b0;
      frame   = init_frame(idx_q, INTENSITY);
      launch  = 1'b0;
      req     = pend_q || update;

      case (state_q)
         SEQ_INIT: begin
            if (update) pend_d = 1'b1;
            if (idx_q == 3'd0) begin
               start = 1'b1;
               idx_d = 3'd1;
            end else if (done) begin
               if (idx_q == 3'(N_INIT_FRAMES)) begin
                  if (req) launch = 1'b1;
                  else     state_d = SEQ_IDLE;
               end else begin
                  start = 1'b1;
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         SEQ_IDLE: begin
            if (update) launch = 1'b1;
         end
         SEQ_DIGITS: begin
            if (update) pend_d = 1'b1;
            if (done) begin
               if (idx_q == 3'(N_DIGIT_FRAMES)) begin
                  if (req) launch = 1'b1;
                  else     state_d = SEQ_IDLE;
               end else begin
                  start = 1'b1;
                  frame = digit_frame(idx_q, snap_q);
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = SEQ_IDLE;
      endcase

      // First digit frame comes straight from the live inputs while the snapshot loads
      if (launch) begin
         state_d = SEQ_DIGITS;
         snap_d  = digits;
         pend_d  = 1'b0;
         start   = 1'b1;
         frame   = digit_frame(3'd0, digits);
         idx_d   = 3'd1;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= SEQ_INIT;
         idx_q   <= 3'd0;
         snap_q  <= 24'h000000;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         pend_q  <= pend_d;
      end
   end

   assign busy = (state_q != SEQ_IDLE);

   spi_frame_tx #(
      .HALF_PERIOD(HALF_PERIOD)
   ) u_frame (
      .clk      (clk),
      .res      (res),
      .start    (start),
      .frame    (frame),
      .done     (done),
      .spi_cs_n (spi_cs_n),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi)
   );

endmodule
